// File: rtl/ex_writeback_scheduler_if.sv
// rtl/ex_writeback_scheduler_if.sv - issue and writeback bundle for the execute writeback scheduler
//
// Signals:
//   issue_valid/ready  : one execute result offered per cycle, accepted when both high
//   issue_rt/lat/data  : target register, unit latency (0 means 1), result value
//   wb_valid/rt/data   : single registered register-file writeback port
// Modports: master drives issues and observes writeback; slave is the scheduler.
interface ex_writeback_scheduler_if #(
  parameter int DATA_W = 128,
  parameter int REG_W  = 7
);
  logic              issue_valid;
  logic              issue_ready;
  logic [REG_W-1:0]  issue_rt;
  logic [2:0]        issue_lat;
  logic [DATA_W-1:0] issue_data;
  logic              wb_valid;
  logic [REG_W-1:0]  wb_rt;
  logic [DATA_W-1:0] wb_data;

  modport master (
    output issue_valid, issue_rt, issue_lat, issue_data,
    input  issue_ready, wb_valid, wb_rt, wb_data
  );

  modport slave (
    input  issue_valid, issue_rt, issue_lat, issue_data,
    output issue_ready, wb_valid, wb_rt, wb_data
  );
endinterface

// File: rtl/ex_writeback_scheduler.sv
// rtl/ex_writeback_scheduler.sv - latency-aware execute result writeback scheduler
//
// Ports:
//   clk, reset       : rising-edge clock, asynchronous active-high reset
//   bus (slave)      : issue_valid/ready/rt/lat/data in, wb_valid/rt/data out
//   flush            : discard every in-flight result at the next edge
//   query_ra/rb/rc   : operand registers checked against pending targets
//   hazard_ra/rb/rc  : queried register has a result still in flight
//   inflight         : number of occupied stages
module ex_writeback_scheduler #(
  parameter int DATA_W  = 128,
  parameter int REG_W   = 7,
  parameter int MAX_LAT = 7
) (
  input  logic                         clk,
  input  logic                         reset,
  ex_writeback_scheduler_if.slave      bus,
  input  logic                         flush,
  input  logic [REG_W-1:0]             query_ra,
  input  logic [REG_W-1:0]             query_rb,
  input  logic [REG_W-1:0]             query_rc,
  output logic                         hazard_ra,
  output logic                         hazard_rb,
  output logic                         hazard_rc,
  output logic [$clog2(MAX_LAT+1)-1:0] inflight
);
  localparam int CNT_W = $clog2(MAX_LAT+1);

  // Stage k holds a result that retires k cycles from now; stage 0 is the
  // writeback register itself.
  logic              st_valid [MAX_LAT];
  logic [REG_W-1:0]  st_rt    [MAX_LAT];
  logic [DATA_W-1:0] st_data  [MAX_LAT];

  logic [2:0] eff_lat;
  logic       accept;

  always_comb begin
    if (bus.issue_lat == 3'd0)
      eff_lat = 3'd1;
    else if (int'(bus.issue_lat) > MAX_LAT)
      eff_lat = 3'(MAX_LAT);
    else
      eff_lat = bus.issue_lat;
  end

  // An issue of latency L lands in stage L-1, which at the same edge would
  // receive stage L. The slot is free exactly when stage L is empty; the
  // top stage always receives a bubble, so MAX_LAT never collides.
  always_comb begin
    bus.issue_ready = !flush;
    for (int k = 1; k < MAX_LAT; k++) begin
      if (int'(eff_lat) == k && st_valid[k])
        bus.issue_ready = 1'b0;
    end
  end

  assign accept = bus.issue_valid && bus.issue_ready && !flush;

  for (genvar k = 0; k < MAX_LAT; k++) begin : g_stage
    logic              up_valid;
    logic [REG_W-1:0]  up_rt;
    logic [DATA_W-1:0] up_data;
    logic              load;

    if (k == MAX_LAT - 1) begin : g_top
      assign up_valid = 1'b0;
      assign up_rt    = '0;
      assign up_data  = '0;
    end else begin : g_shift
      assign up_valid = st_valid[k+1];
      assign up_rt    = st_rt[k+1];
      assign up_data  = st_data[k+1];
    end

    assign load = accept && (int'(eff_lat) == k + 1);

    // rt/data only move with a valid entry, so a flush or a bubble leaves
    // the last written-back rt/data visible on wb_rt/wb_data.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        st_valid[k] <= 1'b0;
        st_rt[k]    <= '0;
        st_data[k]  <= '0;
      end else if (flush) begin
        st_valid[k] <= 1'b0;
      end else if (load) begin
        st_valid[k] <= 1'b1;
        st_rt[k]    <= bus.issue_rt;
        st_data[k]  <= bus.issue_data;
      end else begin
        st_valid[k] <= up_valid;
        if (up_valid) begin
          st_rt[k]   <= up_rt;
          st_data[k] <= up_data;
        end
      end
    end
  end

  always_comb begin
    inflight  = '0;
    hazard_ra = 1'b0;
    hazard_rb = 1'b0;
    hazard_rc = 1'b0;
    for (int k = 0; k < MAX_LAT; k++) begin
      inflight = inflight + CNT_W'(st_valid[k]);
      if (st_valid[k] && st_rt[k] == query_ra) hazard_ra = 1'b1;
      if (st_valid[k] && st_rt[k] == query_rb) hazard_rb = 1'b1;
      if (st_valid[k] && st_rt[k] == query_rc) hazard_rc = 1'b1;
    end
  end

  assign bus.wb_valid = st_valid[0];
  assign bus.wb_rt    = st_rt[0];
  assign bus.wb_data  = st_data[0];
endmodule

// File: tb/tb_ex_writeback_scheduler.sv
// tb/tb_ex_writeback_scheduler.sv - self-checking bench for ex_writeback_scheduler
module tb_ex_writeback_scheduler;
  localparam int DW = 128;
  localparam int RW = 7;
  localparam int ML = 7;

  logic          clk;
  logic          reset;
  logic          flush;
  logic [RW-1:0] query_ra, query_rb, query_rc;
  logic          hazard_ra, hazard_rb, hazard_rc;
  logic [2:0]    inflight;

  ex_writeback_scheduler_if #(.DATA_W(DW), .REG_W(RW)) bus ();

  ex_writeback_scheduler #(.DATA_W(DW), .REG_W(RW), .MAX_LAT(ML)) dut (
    .clk(clk), .reset(reset), .bus(bus), .flush(flush),
    .query_ra(query_ra), .query_rb(query_rb), .query_rc(query_rc),
    .hazard_ra(hazard_ra), .hazard_rb(hazard_rb), .hazard_rc(hazard_rc),
    .inflight(inflight)
  );

  always #5 clk = ~clk;

  // Reference model: a list of pending results, each due to be written back
  // in a known absolute cycle.
  typedef struct {
    int            due;
    logic [RW-1:0] rt;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          pend[$];
  int            cyc;
  logic [RW-1:0] last_rt;
  logic [DW-1:0] last_data;
  int            n_vec;
  int            n_err;

  function automatic int m_eff(input logic [2:0] lat);
    if (lat == 3'd0) return 1;
    if (int'(lat) > ML) return ML;
    return int'(lat);
  endfunction

  function automatic bit m_ready(input int eff, input bit fl);
    if (fl) return 1'b0;
    foreach (pend[i]) if (pend[i].due == cyc + eff) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_wb_valid();
    foreach (pend[i]) if (pend[i].due == cyc) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [RW-1:0] m_wb_rt();
    foreach (pend[i]) if (pend[i].due == cyc) return pend[i].rt;
    return last_rt;
  endfunction

  function automatic logic [DW-1:0] m_wb_data();
    foreach (pend[i]) if (pend[i].due == cyc) return pend[i].data;
    return last_data;
  endfunction

  function automatic bit m_hazard(input logic [RW-1:0] q);
    foreach (pend[i]) if (pend[i].rt == q) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_inflight();
    return pend.size();
  endfunction

  task automatic model_clear();
    pend.delete();
    last_rt   = '0;
    last_data = '0;
  endtask

  task automatic drive(input bit v, input logic [RW-1:0] rt, input logic [2:0] lat,
                       input logic [DW-1:0] d, input bit fl);
    bus.issue_valid = v;
    bus.issue_rt    = rt;
    bus.issue_lat   = lat;
    bus.issue_data  = d;
    flush           = fl;
  endtask

  task automatic idle();
    drive(1'b0, '0, 3'd1, '0, 1'b0);
  endtask

  // Advance one clock edge, updating the model from the inputs being driven.
  task automatic tick();
    bit   acc;
    bit   fl;
    int   eff;
    ent_t e;
    eff    = m_eff(bus.issue_lat);
    fl     = flush;
    acc    = (bus.issue_valid === 1'b1) && m_ready(eff, fl);
    e.due  = cyc + eff;
    e.rt   = bus.issue_rt;
    e.data = bus.issue_data;
    @(posedge clk);
    for (int i = pend.size() - 1; i >= 0; i--) begin
      if (pend[i].due == cyc) begin
        last_rt   = pend[i].rt;
        last_data = pend[i].data;
        pend.delete(i);
      end
    end
    if (fl) pend.delete();
    if (acc) pend.push_back(e);
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    query_ra = '0; query_rb = '0; query_rc = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++; if (bus.wb_valid !== 1'b0) begin n_err++; $display("FAIL reset.wb_valid got %b exp 0", bus.wb_valid); end
    n_vec++; if (bus.wb_rt !== '0) begin n_err++; $display("FAIL reset.wb_rt got %0d exp 0", bus.wb_rt); end
    n_vec++; if (bus.wb_data !== '0) begin n_err++; $display("FAIL reset.wb_data got %h exp 0", bus.wb_data); end
    n_vec++; if (inflight !== 3'd0) begin n_err++; $display("FAIL reset.inflight got %0d exp 0", inflight); end
    n_vec++; if (hazard_ra !== 1'b0) begin n_err++; $display("FAIL reset.hazard_ra got %b exp 0", hazard_ra); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    cyc = 0;
    @(negedge clk);
    n_vec++; if (bus.issue_ready !== 1'b1) begin n_err++; $display("FAIL reset.issue_ready got %b exp 1", bus.issue_ready); end
    tick();
  endtask

  task automatic test_single();
    query_ra = 7'd5; query_rb = 7'd127; query_rc = 7'd127;
    for (int c = 0; c < 4; c++) begin
      if (c == 0) drive(1'b1, 7'd5, 3'd2, 128'h1234, 1'b0); else idle();
      @(negedge clk);
      n_vec++; if (hazard_ra !== (c == 1 || c == 2)) begin n_err++; $display("FAIL single.hazard_ra cycle %0d got %b exp %b", c, hazard_ra, (c == 1 || c == 2)); end
      n_vec++; if (bus.wb_valid !== (c == 2)) begin n_err++; $display("FAIL single.wb_valid cycle %0d got %b exp %b", c, bus.wb_valid, (c == 2)); end
      if (c == 2) begin
        n_vec++; if (bus.wb_rt !== 7'd5 || bus.wb_data !== 128'h1234) begin n_err++; $display("FAIL single.wb_payload got rt=%0d data=%h exp rt=5 data=1234", bus.wb_rt, bus.wb_data); end
      end
      tick();
    end
  endtask

  task automatic test_collision();
    query_ra = 7'd1; query_rb = 7'd9; query_rc = 7'd127;
    drive(1'b1, 7'd1, 3'd4, 128'hA1, 1'b0);
    @(negedge clk);
    n_vec++; if (bus.issue_ready !== 1'b1) begin n_err++; $display("FAIL collision.ready_c0 got %b exp 1", bus.issue_ready); end
    tick();
    drive(1'b1, 7'd9, 3'd3, 128'hB2, 1'b0);
    @(negedge clk);
    n_vec++; if (bus.issue_ready !== 1'b0) begin n_err++; $display("FAIL collision.ready_l3 got %b exp 0", bus.issue_ready); end
    bus.issue_lat = 3'd2;
    #1;
    n_vec++; if (bus.issue_ready !== 1'b1) begin n_err++; $display("FAIL collision.ready_l2 got %b exp 1", bus.issue_ready); end
    tick();
    for (int c = 2; c < 6; c++) begin
      idle();
      @(negedge clk);
      n_vec++; if (bus.wb_valid !== (c == 3 || c == 4)) begin n_err++; $display("FAIL collision.wb_valid cycle %0d got %b exp %b", c, bus.wb_valid, (c == 3 || c == 4)); end
      if (c == 3) begin
        n_vec++; if (bus.wb_rt !== 7'd9 || bus.wb_data !== 128'hB2) begin n_err++; $display("FAIL collision.wb_c3 got rt=%0d data=%h exp rt=9 data=b2", bus.wb_rt, bus.wb_data); end
      end
      if (c == 4) begin
        n_vec++; if (bus.wb_rt !== 7'd1 || bus.wb_data !== 128'hA1) begin n_err++; $display("FAIL collision.wb_c4 got rt=%0d data=%h exp rt=1 data=a1", bus.wb_rt, bus.wb_data); end
      end
      tick();
    end
  endtask

  task automatic test_out_of_order();
    query_ra = 7'd10; query_rb = 7'd11; query_rc = 7'd12;
    for (int c = 0; c < 9; c++) begin
      if (c == 0) drive(1'b1, 7'd10, 3'd7, 128'h10, 1'b0);
      else if (c == 1) drive(1'b1, 7'd11, 3'd1, 128'h11, 1'b0);
      else idle();
      @(negedge clk);
      n_vec++; if (bus.wb_valid !== (c == 2 || c == 7)) begin n_err++; $display("FAIL ooo.wb_valid cycle %0d got %b exp %b", c, bus.wb_valid, (c == 2 || c == 7)); end
      if (c == 2 || c == 7) begin
        n_vec++; if (bus.wb_rt !== ((c == 2) ? 7'd11 : 7'd10)) begin n_err++; $display("FAIL ooo.wb_rt cycle %0d got %0d exp %0d", c, bus.wb_rt, (c == 2) ? 11 : 10); end
      end
      n_vec++; if (int'(inflight) !== m_inflight()) begin n_err++; $display("FAIL ooo.inflight cycle %0d got %0d exp %0d", c, inflight, m_inflight()); end
      n_vec++; if (hazard_ra !== m_hazard(query_ra) || hazard_rb !== m_hazard(query_rb)) begin n_err++; $display("FAIL ooo.hazard cycle %0d got ra=%b rb=%b exp ra=%b rb=%b", c, hazard_ra, hazard_rb, m_hazard(query_ra), m_hazard(query_rb)); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 17; c++) begin
      if (c < 16) drive(1'b1, 7'(c), 3'd1, 128'(c), 1'b0); else idle();
      @(negedge clk);
      if (c < 16) begin
        n_vec++; if (bus.issue_ready !== 1'b1) begin n_err++; $display("FAIL stream.ready cycle %0d got %b exp 1", c, bus.issue_ready); end
      end
      if (c >= 1) begin
        n_vec++; if (bus.wb_valid !== 1'b1 || bus.wb_rt !== 7'(c - 1) || bus.wb_data !== 128'(c - 1)) begin n_err++; $display("FAIL stream.wb cycle %0d got v=%b rt=%0d data=%h exp v=1 rt=%0d", c, bus.wb_valid, bus.wb_rt, bus.wb_data, c - 1); end
        n_vec++; if (inflight !== 3'd1) begin n_err++; $display("FAIL stream.inflight cycle %0d got %0d exp 1", c, inflight); end
      end
      tick();
    end
    // Equal maximum latency, issued back to back, must never be refused.
    for (int c = 0; c < 12; c++) begin
      if (c < 4) drive(1'b1, 7'(20 + c), 3'd7, 128'(c + 100), 1'b0); else idle();
      @(negedge clk);
      if (c < 4) begin
        n_vec++; if (bus.issue_ready !== 1'b1) begin n_err++; $display("FAIL b2b.ready cycle %0d got %b exp 1", c, bus.issue_ready); end
      end
      n_vec++; if (bus.wb_valid !== m_wb_valid()) begin n_err++; $display("FAIL b2b.wb_valid cycle %0d got %b exp %b", c, bus.wb_valid, m_wb_valid()); end
      if (m_wb_valid()) begin
        n_vec++; if (bus.wb_rt !== m_wb_rt()) begin n_err++; $display("FAIL b2b.wb_rt cycle %0d got %0d exp %0d", c, bus.wb_rt, m_wb_rt()); end
      end
      tick();
    end
  endtask

  task automatic test_flush();
    query_ra = 7'd2; query_rb = 7'd4; query_rc = 7'd7;
    drive(1'b1, 7'd2, 3'd3, 128'h22, 1'b0);
    @(negedge clk);
    tick();
    drive(1'b1, 7'd4, 3'd6, 128'h44, 1'b0);
    @(negedge clk);
    tick();
    drive(1'b1, 7'd7, 3'd1, 128'h77, 1'b1);
    @(negedge clk);
    n_vec++; if (bus.issue_ready !== 1'b0) begin n_err++; $display("FAIL flush.ready got %b exp 0", bus.issue_ready); end
    n_vec++; if (inflight !== 3'd2) begin n_err++; $display("FAIL flush.inflight_before got %0d exp 2", inflight); end
    tick();
    for (int c = 3; c < 10; c++) begin
      idle();
      @(negedge clk);
      n_vec++; if (bus.wb_valid !== 1'b0) begin n_err++; $display("FAIL flush.wb_valid cycle %0d got %b exp 0", c, bus.wb_valid); end
      n_vec++; if (inflight !== 3'd0) begin n_err++; $display("FAIL flush.inflight cycle %0d got %0d exp 0", c, inflight); end
      if (c == 3) begin
        n_vec++; if (bus.wb_rt !== last_rt || bus.wb_data !== last_data) begin n_err++; $display("FAIL flush.hold got rt=%0d data=%h exp rt=%0d data=%h", bus.wb_rt, bus.wb_data, last_rt, last_data); end
        n_vec++; if (hazard_rc !== 1'b0) begin n_err++; $display("FAIL flush.dropped_issue_hazard got %b exp 0", hazard_rc); end
      end
      tick();
    end
  endtask

  task automatic test_reset_midflight();
    query_ra = 7'd3; query_rb = 7'd127; query_rc = 7'd127;
    for (int c = 0; c < 3; c++) begin
      if (c == 0) drive(1'b1, 7'd3, 3'd5, 128'h33, 1'b0); else idle();
      @(negedge clk);
      n_vec++; if (bus.wb_valid !== 1'b0) begin n_err++; $display("FAIL rstmid.wb_valid cycle %0d got %b exp 0", c, bus.wb_valid); end
      if (c < 2) tick();
    end
    reset = 1'b1;
    #1;
    model_clear();
    n_vec++; if (inflight !== 3'd0) begin n_err++; $display("FAIL rstmid.inflight got %0d exp 0", inflight); end
    n_vec++; if (bus.wb_valid !== 1'b0 || bus.wb_rt !== '0 || bus.wb_data !== '0) begin n_err++; $display("FAIL rstmid.wb got v=%b rt=%0d data=%h exp all 0", bus.wb_valid, bus.wb_rt, bus.wb_data); end
    n_vec++; if (hazard_ra !== 1'b0) begin n_err++; $display("FAIL rstmid.hazard got %b exp 0", hazard_ra); end
    @(posedge clk);
    cyc++;
    #1;
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      idle();
      @(negedge clk);
      n_vec++; if (bus.wb_valid !== 1'b0 || inflight !== 3'd0) begin n_err++; $display("FAIL rstmid.after cycle %0d got v=%b inflight=%0d exp 0 0", c, bus.wb_valid, inflight); end
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive(($urandom % 10) < 7, 7'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
            {$urandom, $urandom, $urandom, $urandom}, ($urandom % 32) == 0);
      query_ra = 7'($urandom_range(0, 15));
      query_rb = 7'($urandom_range(0, 15));
      query_rc = 7'($urandom_range(0, 15));
      @(negedge clk);
      n_vec++; if (bus.issue_ready !== m_ready(m_eff(bus.issue_lat), flush)) begin n_err++; $display("FAIL rand.ready step %0d lat=%0d got %b exp %b", c, bus.issue_lat, bus.issue_ready, m_ready(m_eff(bus.issue_lat), flush)); end
      n_vec++; if (hazard_ra !== m_hazard(query_ra) || hazard_rb !== m_hazard(query_rb) || hazard_rc !== m_hazard(query_rc)) begin n_err++; $display("FAIL rand.hazard step %0d got %b%b%b exp %b%b%b", c, hazard_ra, hazard_rb, hazard_rc, m_hazard(query_ra), m_hazard(query_rb), m_hazard(query_rc)); end
      n_vec++; if (bus.wb_valid !== m_wb_valid()) begin n_err++; $display("FAIL rand.wb_valid step %0d got %b exp %b", c, bus.wb_valid, m_wb_valid()); end
      if (m_wb_valid()) begin
        n_vec++; if (bus.wb_rt !== m_wb_rt() || bus.wb_data !== m_wb_data()) begin n_err++; $display("FAIL rand.wb_payload step %0d got rt=%0d data=%h exp rt=%0d data=%h", c, bus.wb_rt, bus.wb_data, m_wb_rt(), m_wb_data()); end
      end
      n_vec++; if (int'(inflight) !== m_inflight()) begin n_err++; $display("FAIL rand.inflight step %0d got %0d exp %0d", c, inflight, m_inflight()); end
      tick();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    clk   = 1'b0;
    reset = 1'b1;
    n_vec = 0;
    n_err = 0;
    cyc   = 0;
    model_clear();
    idle();
    query_ra = '0; query_rb = '0; query_rc = '0;
    test_reset();
    test_single();
    test_collision();
    test_out_of_order();
    test_back_to_back();
    test_flush();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
